// File: rtl/cmp_multi.sv
/*-----------------------------------------------------------------------------
 * Module : cmp_multi
 * Brief  : Multi-channel signed comparator with per-channel persistence filter.
 * Rev    : 1.0 - initial release
 *---------------------------------------------------------------------------*/
`default_nettype none

module cmp_multi #(
  parameter int DATA_W  = 16,
  parameter int CH      = 4,
  parameter int PERSIST = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [CH*DATA_W-1:0] a,
  input  logic [CH*DATA_W-1:0] b,
  input  logic [2:0]           mode,
  output logic                 out_valid,
  output logic [CH-1:0]        r_raw,
  output logic [CH-1:0]        r,
  output logic                 any,
  output logic                 all
);

  localparam int              CNT_W = (PERSIST < 1) ? 1 : $clog2(PERSIST + 1);
  localparam logic [CNT_W-1:0] C_SAT = CNT_W'(PERSIST);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  localparam logic [2:0] C_MODE_GTE = 3'd0;
  localparam logic [2:0] C_MODE_GT  = 3'd1;
  localparam logic [2:0] C_MODE_LTE = 3'd2;
  localparam logic [2:0] C_MODE_LT  = 3'd3;
  localparam logic [2:0] C_MODE_EQ  = 3'd4;
  localparam logic [2:0] C_MODE_NE  = 3'd5;

  function automatic logic f_cmp(input logic signed [DATA_W-1:0] x,
                                 input logic signed [DATA_W-1:0] y,
                                 input logic [2:0]               m);
    logic res;
    res = 1'b0;
    case (m)
      C_MODE_GTE: res = (x >= y);
      C_MODE_GT:  res = (x >  y);
      C_MODE_LTE: res = (x <= y);
      C_MODE_LT:  res = (x <  y);
      C_MODE_EQ:  res = (x == y);
      C_MODE_NE:  res = (x != y);
      default:    res = 1'b0;
    endcase
    return res;
  endfunction

  logic [2:0]    r_mode;
  logic          w_mode_chg;
  logic [CH-1:0] w_raw;
  logic [CH-1:0] w_filt;

  // A new mode invalidates every channel's history before the sample is counted
  assign w_mode_chg = (mode != r_mode);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic signed [DATA_W-1:0] w_a;
    logic signed [DATA_W-1:0] w_b;
    logic                     w_res;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         w_base;
    logic [CNT_W-1:0]         w_cnt_nxt;

    assign w_a   = a[i*DATA_W +: DATA_W];
    assign w_b   = b[i*DATA_W +: DATA_W];
    assign w_res = f_cmp(w_a, w_b, mode);

    assign w_base    = w_mode_chg ? '0 : r_cnt;
    assign w_cnt_nxt = !w_res           ? '0    :
                       (w_base == C_SAT) ? C_SAT : (w_base + C_ONE);

    assign w_raw[i]  = w_res;
    assign w_filt[i] = (w_cnt_nxt == C_SAT);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (in_valid) begin
        r_cnt <= w_cnt_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      r_raw     <= '0;
      r         <= '0;
      any       <= 1'b0;
      all       <= 1'b0;
      r_mode    <= C_MODE_GTE;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        r_raw  <= w_raw;
        r      <= w_filt;
        any    <= |w_filt;
        all    <= &w_filt;
        r_mode <= mode;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cmp_multi.sv
/*-----------------------------------------------------------------------------
 * Module : tb_cmp_multi
 * Brief  : Directed self-checking bench for cmp_multi.
 * Rev    : 1.0 - initial release
 *---------------------------------------------------------------------------*/
`default_nettype none

module tb_cmp_multi;

  localparam int DATA_W = 16;
  localparam int CH     = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic [CH*DATA_W-1:0] a = '0;
  logic [CH*DATA_W-1:0] b = '0;
  logic [2:0]           mode = 3'd0;
  logic                 out_valid;
  logic [CH-1:0]        r_raw;
  logic [CH-1:0]        r;
  logic                 any;
  logic                 all;
  logic                 out_valid_p1;
  logic [CH-1:0]        r_raw_p1;
  logic [CH-1:0]        r_p1;
  logic                 any_p1;
  logic                 all_p1;

  int n_checks = 0;
  int n_fail   = 0;

  cmp_multi #(.DATA_W(DATA_W), .CH(CH), .PERSIST(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .mode(mode),
    .out_valid(out_valid), .r_raw(r_raw), .r(r), .any(any), .all(all)
  );

  cmp_multi #(.DATA_W(DATA_W), .CH(CH), .PERSIST(1)) u_dut_p1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .mode(mode),
    .out_valid(out_valid_p1), .r_raw(r_raw_p1), .r(r_p1), .any(any_p1), .all(all_p1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CH*DATA_W-1:0] pack(input logic [15:0] v0, input logic [15:0] v1,
                                                input logic [15:0] v2, input logic [15:0] v3);
    return {v3, v2, v1, v0};
  endfunction

  // Drive one cycle's inputs at the falling edge, then sample just after the rising edge
  task automatic step(input logic iv, input logic [CH*DATA_W-1:0] av,
                      input logic [CH*DATA_W-1:0] bv, input logic [2:0] m);
    @(negedge clk);
    in_valid = iv;
    a        = av;
    b        = bv;
    mode     = m;
    @(posedge clk);
    #1;
  endtask

  logic [CH*DATA_W-1:0] all_t_a, all_t_b, all_f_a, all_f_b;
  logic [7:0]           mode_exp;

  initial begin
    all_t_a  = pack(16'd1, 16'd1, 16'd1, 16'd1);
    all_t_b  = pack(16'd0, 16'd0, 16'd0, 16'd0);
    all_f_a  = pack(16'd0, 16'd0, 16'd0, 16'd0);
    all_f_b  = pack(16'd1, 16'd1, 16'd1, 16'd1);
    mode_exp = 8'b0010_1100;  // bit m = expected result of -5 op 3

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_r_raw", 32'(r_raw), 32'd0);
    check("rst_r", 32'(r), 32'd0);
    check("rst_any_all", 32'({any, all}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Boundary signed compares, mode GTE
    step(1'b1, pack(16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000),
               pack(16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000), 3'd0);
    check("edge_out_valid", 32'(out_valid), 32'd1);
    check("edge_r_raw", 32'(r_raw), 32'b1110);
    check("edge_r", 32'(r), 32'b0000);
    check("p1_r_eq_raw", 32'(r_p1), 32'b1110);

    // All modes on -5 vs 3
    for (int m = 0; m < 8; m++) begin
      step(1'b1, pack(16'hFFFB, 16'd0, 16'd0, 16'd0), pack(16'd3, 16'd0, 16'd0, 16'd0), 3'(m));
      check($sformatf("mode%0d_raw0", m), 32'(r_raw[0]), 32'(mode_exp[m]));
    end

    // Persistence with in_valid gaps
    step(1'b1, all_t_a, all_t_b, 3'd0);
    check("pers_t1_r", 32'(r), 32'h0);
    step(1'b0, all_t_a, all_t_b, 3'd0);
    check("pers_gap_out_valid", 32'(out_valid), 32'd0);
    check("pers_gap_r", 32'(r), 32'h0);
    step(1'b1, all_t_a, all_t_b, 3'd0);
    check("pers_t2_r", 32'(r), 32'h0);
    step(1'b0, all_t_a, all_t_b, 3'd0);
    step(1'b1, all_t_a, all_t_b, 3'd0);
    check("pers_t3_r", 32'(r), 32'hF);
    check("pers_t3_any_all", 32'({any, all}), 32'b11);
    step(1'b0, all_f_a, all_f_b, 3'd0);
    check("pers_gap2_hold", 32'({out_valid, r}), 32'h0F);
    step(1'b1, all_t_a, all_t_b, 3'd0);
    check("pers_t4_sat_r", 32'(r), 32'hF);
    step(1'b1, all_f_a, all_f_b, 3'd0);
    check("pers_false_r", 32'(r), 32'h0);
    check("pers_false_raw", 32'(r_raw), 32'h0);
    check("pers_false_any", 32'(any), 32'd0);
    check("p1_false_r", 32'(r_p1), 32'h0);

    // Mode change restarts counters
    step(1'b1, all_t_a, all_t_b, 3'd0);
    step(1'b1, all_t_a, all_t_b, 3'd0);
    check("mchg_pre_r", 32'(r), 32'h0);
    step(1'b1, all_t_a, all_t_b, 3'd1);
    check("mchg_new_r", 32'(r), 32'h0);
    step(1'b1, all_t_a, all_t_b, 3'd1);
    check("mchg_cnt2_r", 32'(r), 32'h0);
    step(1'b1, all_t_a, all_t_b, 3'd1);
    check("mchg_cnt3_r", 32'(r), 32'hF);

    // any/all with channel 2 lagging
    step(1'b1, pack(16'd1, 16'd1, 16'd0, 16'd1), pack(16'd0, 16'd0, 16'd1, 16'd0), 3'd1);
    check("ch2_low_r", 32'(r), 32'b1011);
    check("ch2_low_any_all", 32'({any, all}), 32'b10);
    step(1'b1, all_t_a, all_t_b, 3'd1);
    check("ch2_c1_all", 32'({r, all}), 32'b1011_0);
    step(1'b1, all_t_a, all_t_b, 3'd1);
    check("ch2_c2_all", 32'({r, all}), 32'b1011_0);
    step(1'b1, all_t_a, all_t_b, 3'd1);
    check("ch2_c3_all", 32'({r, any, all}), 32'b1111_11);

    // Asynchronous reset mid-sequence
    check("arst_pre_out_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("arst_r", 32'(r), 32'h0);
    check("arst_any_out_valid", 32'({any, all, out_valid}), 32'd0);
    #3;
    rst_n = 1'b1;
    step(1'b1, all_t_a, all_t_b, 3'd1);
    check("post_rst_t1", 32'({out_valid, r_raw, r}), 32'b1_1111_0000);
    step(1'b1, all_t_a, all_t_b, 3'd1);
    check("post_rst_t2_r", 32'(r), 32'h0);
    step(1'b1, all_t_a, all_t_b, 3'd1);
    check("post_rst_t3_r", 32'(r), 32'hF);

    step(1'b0, all_t_a, all_t_b, 3'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cmp_multi.md
CMP_MULTI -- requirements
Module: cmp_multi

Interface
REQ-001 Parameter DATA_W, default 16: width of each signed two's-complement operand.
REQ-002 Parameter CH, default 4: number of independent comparator channels, CH >= 1.
REQ-003 Parameter PERSIST, default 3: consecutive true samples required before a channel's filtered result asserts; PERSIST >= 1.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  sample strobe; a, b and mode are captured only when it is high.
REQ-007 a  input  CH*DATA_W  packed operands; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-008 b  input  CH*DATA_W  packed operands, same packing as a.
REQ-009 mode  input  3  operation shared by all channels: 0 GTE, 1 GT, 2 LTE, 3 LT, 4 EQ, 5 NE, 6-7 reserved.
REQ-010 out_valid  output  1  high for one cycle per accepted sample.
REQ-011 r_raw  output  CH  registered unfiltered compare result per channel.
REQ-012 r  output  CH  registered persistence-filtered result per channel.
REQ-013 any  output  1  registered OR of the next-state value of r.
REQ-014 all  output  1  registered AND of the next-state value of r.

Function
REQ-015 The block SHALL evaluate "a_i op b_i" as a full signed comparison, correct for all operand pairs including the most-negative value and mixed signs.
REQ-016 Reserved modes 6-7 SHALL produce a false result on every channel.
REQ-017 Latency SHALL be 1 cycle: a sample accepted at edge t SHALL appear on out_valid, r_raw, r, any and all after edge t.
REQ-018 A cycle with in_valid low SHALL drive out_valid low and hold r_raw, r, any, all and all counters unchanged.
REQ-019 Each channel SHALL keep a saturating counter of width clog2(PERSIST+1).
REQ-020 On an accepted sample, a true result SHALL increment the counter, saturating at PERSIST; a false result SHALL clear it to 0.
REQ-021 r[i] SHALL be loaded with (counter_next == PERSIST) on every accepted sample.
REQ-022 With PERSIST = 1, r SHALL equal r_raw on every cycle.
REQ-023 If the mode of an accepted sample differs from the mode of the previous accepted sample, all counters SHALL restart from 0 before that sample is counted, so a true result yields counter 1.
REQ-024 Mode change detection SHALL use a registered copy of the last accepted mode; that register SHALL reset to 0 (GTE).
REQ-025 in_valid held high on consecutive cycles SHALL accept one sample per cycle with no bubbles.
REQ-026 Once saturated, the counter SHALL stay at PERSIST on further true samples; r SHALL remain 1 and SHALL NOT wrap.

Reset
REQ-027 Asserting rst_n low SHALL immediately clear out_valid, r_raw, r, any, all, all counters and the mode register to 0, without waiting for a clock edge.
REQ-028 Reset asserted mid-sequence SHALL discard all partial persistence history; after release, PERSIST fresh true samples are required before r asserts.
REQ-029 The first rising edge with rst_n high SHALL accept a sample normally if in_valid is high.

Verification
REQ-030 DATA_W=16, PERSIST=3, mode 0: a=0x8000, b=0x7FFF -> r_raw=0; a=0x7FFF, b=0x8000 -> r_raw=1; a=b=0xFFFF -> r_raw=1.
REQ-031 All modes 0-7 on a channel with a=-5 and b=3 -> r_raw=0,0,1,1,0,1,0,0 respectively.
REQ-032 PERSIST=3: true samples T,T,T,T with in_valid gaps between them -> r=0,0,1,1; out_valid pulses only on the sample cycles; then one false sample -> r=0, counter 0.
REQ-033 PERSIST=3: two true samples in mode 0, then a true sample in mode 1 -> r stays 0 (counter 1); two further mode-1 true samples -> r=1.
REQ-034 CH=4: channels 0-3 saturated true except channel 2 -> any=1, all=0; channel 2 reaches PERSIST -> all=1 in the same cycle r[2] rises.
REQ-035 Saturate a channel (r=1), then pulse rst_n low between clock edges -> r, any and out_valid drop to 0 asynchronously; after release, r rises only on the third true sample.
